// File: rtl/spi_arb_pkg.sv
// Shared types for the SPI master share arbiter.
// Arbiter state encoding and owner index.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  // 0 = A2D interface, 1 = inertial sensor interface
  typedef logic owner_t;

  localparam owner_t OWNER_A2D   = 1'b0;
  localparam owner_t OWNER_INERT = 1'b1;

endpackage

// File: rtl/spi_share_arb.sv
// Shares one SPI_mnrch master between the A2D and inertial requesters.
// Ports: clk, rst_n (sync, active low); req/wrt/wrt_data per requester;
// gnt/done per requester; rd_data broadcast; m_* to/from the master;
// SS_n0/SS_n1 routed chip selects; tmo pulses on an idle-owner revoke.
module spi_share_arb
  import spi_arb_pkg::*;
#(
  parameter int GAP_CYC = 4,
  parameter int TMO_CYC = 1024,
  parameter int TMO_W   = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        wrt0,
  input  logic        wrt1,
  input  logic [15:0] wrt_data0,
  input  logic [15:0] wrt_data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] rd_data,
  output logic        m_wrt,
  output logic [15:0] m_wrt_data,
  input  logic        m_done,
  input  logic [15:0] m_rd_data,
  input  logic        m_SS_n,
  output logic        SS_n0,
  output logic        SS_n1,
  output logic        tmo
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  localparam logic [TMO_W-1:0] GAP_LAST = TMO_W'(GAP_CYC - 1);

  arb_state_t       state;
  owner_t           owner;
  owner_t           last_owner;
  logic             busy;
  logic [TMO_W-1:0] cnt;
  // Requesters revoked by timeout stay locked out until they drop req.
  logic [1:0]       blk;

  logic        in_own;
  logic        own_req;
  logic        own_wrt;
  logic [15:0] own_data;
  logic        fwd;
  logic        rel;
  logic [1:0]  elig;
  owner_t      pick;

  assign in_own   = (state == OWN);
  assign own_req  = owner ? req1 : req0;
  assign own_wrt  = owner ? wrt1 : wrt0;
  assign own_data = owner ? wrt_data1 : wrt_data0;

  // The master is only ever started while idle.
  assign fwd = in_own && own_wrt && !busy;

  // An m_done in the same cycle counts as not busy.
  assign rel = in_own && !own_req && !fwd
             && !(busy && !m_done);

  assign elig = {req1 & ~blk[1], req0 & ~blk[0]};
  assign pick = (elig == 2'b11) ? ~last_owner
                                : elig[1];

  assign m_wrt      = fwd;
  assign m_wrt_data = fwd ? own_data : 16'h0000;

  assign gnt0 = in_own && (owner == OWNER_A2D);
  assign gnt1 = in_own && (owner == OWNER_INERT);

  assign done0 = gnt0 && busy && m_done;
  assign done1 = gnt1 && busy && m_done;

  assign SS_n0 = gnt0 ? m_SS_n : 1'b1;
  assign SS_n1 = gnt1 ? m_SS_n : 1'b1;

  assign rd_data = m_rd_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWNER_A2D;
      last_owner <= OWNER_INERT;
      busy       <= 1'b0;
      cnt        <= '0;
      blk        <= 2'b00;
      tmo        <= 1'b0;
    end else begin
      tmo <= 1'b0;
      if (!req0) blk[0] <= 1'b0;
      if (!req1) blk[1] <= 1'b0;
      unique case (state)
        IDLE: begin
          if (elig != 2'b00) begin
            state <= OWN;
            owner <= pick;
            busy  <= 1'b0;
            cnt   <= '0;
          end
        end
        OWN: begin
          if (rel) begin
            state      <= GAP;
            last_owner <= owner;
            busy       <= 1'b0;
            cnt        <= '0;
          end else if (fwd) begin
            busy <= 1'b1;
            cnt  <= '0;
          end else if (busy) begin
            if (m_done) busy <= 1'b0;
          end else if (cnt == TMO_LAST) begin
            tmo        <= 1'b1;
            state      <= GAP;
            last_owner <= owner;
            blk[owner] <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + TMO_W'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + TMO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_share_arb.sv
// Self-checking bench for spi_share_arb.
// Directed table, corner sequences, then random traffic vs a model.
module tb_spi_share_arb;

  localparam int GAP = 4;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, wrt0, wrt1;
  logic [15:0] wrt_data0, wrt_data1;
  logic        gnt0, gnt1, done0, done1;
  logic [15:0] rd_data;
  logic        m_wrt;
  logic [15:0] m_wrt_data;
  logic        m_done;
  logic [15:0] m_rd_data;
  logic        m_SS_n;
  logic        SS_n0, SS_n1, tmo;

  spi_share_arb #(
    .GAP_CYC(GAP),
    .TMO_CYC(TMO),
    .TMO_W(5)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .wrt0(wrt0), .wrt1(wrt1),
    .wrt_data0(wrt_data0), .wrt_data1(wrt_data1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .rd_data(rd_data),
    .m_wrt(m_wrt), .m_wrt_data(m_wrt_data),
    .m_done(m_done), .m_rd_data(m_rd_data),
    .m_SS_n(m_SS_n),
    .SS_n0(SS_n0), .SS_n1(SS_n1),
    .tmo(tmo)
  );

  always #5 clk = ~clk;

  // {gnt0,gnt1,done0,done1,m_wrt,SS_n0,SS_n1,tmo}
  logic [7:0] obs;
  assign obs = {gnt0, gnt1, done0, done1,
                m_wrt, SS_n0, SS_n1, tmo};

  int total = 0;
  int passed = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  task automatic set_in(input logic q0, q1, w0, w1,
                        input logic [15:0] d0, d1,
                        input logic md, ss);
    req0 = q0; req1 = q1;
    wrt0 = w0; wrt1 = w1;
    wrt_data0 = d0; wrt_data1 = d1;
    m_done = md; m_SS_n = ss;
  endtask

  // One cycle: drive after the falling edge, settle, return.
  task automatic cyc(input logic q0, q1, w0, w1,
                     input logic [15:0] d0, d1,
                     input logic md, ss);
    @(negedge clk);
    set_in(q0, q1, w0, w1, d0, d1, md, ss);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    m_rd_data = 16'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
  endtask

  typedef struct {
    logic        q0, q1, w0, w1;
    logic [15:0] d0, d1;
    logic        md, ss;
    logic [15:0] rd;
    logic [7:0]  eo;
    logic [15:0] ed;
  } vec_t;

  vec_t tbl[10];

  // ---- behavioural reference model ----
  int         own;       // -1 none, else owning requester
  int         gap_left;
  int         idle_run;
  int         last;
  bit         inflight;
  bit         blocked[2];
  bit         tmo_m;
  int         xfer;      // bench master: cycles left in transfer
  logic [1:0] rq, wr;
  logic [15:0] wd[2];

  task automatic model_reset();
    own = -1; gap_left = 0; idle_run = 0; last = 1;
    inflight = 0; blocked[0] = 0; blocked[1] = 0;
    tmo_m = 0; xfer = 0;
  endtask

  function automatic bit m_fwd();
    return (own >= 0) && wr[own] && !inflight;
  endfunction

  function automatic logic [7:0] m_obs(bit md, bit ss);
    bit f;
    f = m_fwd();
    return {own == 0, own == 1,
            own == 0 && inflight && md,
            own == 1 && inflight && md,
            f,
            own == 0 ? ss : 1'b1,
            own == 1 ? ss : 1'b1,
            tmo_m};
  endfunction

  task automatic model_step(bit rs, bit md);
    bit f, still, e0, e1;
    f = m_fwd();
    if (!rs) begin
      model_reset();
      return;
    end
    if (f) xfer = $urandom_range(6, 2);
    else if (xfer > 0) xfer--;
    tmo_m = 0;
    for (int i = 0; i < 2; i++)
      if (!rq[i]) blocked[i] = 0;
    if (own < 0) begin
      if (gap_left > 0) gap_left--;
      else begin
        e0 = rq[0] && !blocked[0];
        e1 = rq[1] && !blocked[1];
        if (e0 && e1) own = 1 - last;
        else if (e0) own = 0;
        else if (e1) own = 1;
        idle_run = 0;
        inflight = 0;
      end
    end else begin
      still = inflight && !md;
      if (!rq[own] && !still && !f) begin
        last = own; own = -1; gap_left = GAP;
        inflight = 0;
      end else if (f) begin
        inflight = 1; idle_run = 0;
      end else if (inflight) begin
        if (md) inflight = 0;
      end else begin
        idle_run++;
        if (idle_run == TMO) begin
          tmo_m = 1; blocked[own] = 1;
          last = own; own = -1; gap_left = GAP;
        end
      end
    end
  endtask

  int fk, gi, ti, nd0, nd1, drop, g1seen, regr, found;

  initial begin
    rst_n = 1'b0;
    m_rd_data = 16'h0;
    set_in(0, 0, 0, 0, 0, 0, 0, 1);

    // q0 q1 w0 w1 d0 d1 md ss rd eo ed
    tbl[0] = '{0,0,0,0,16'h0,16'h0,0,1,16'h1111,8'h06,16'h0};
    tbl[1] = '{1,0,0,0,16'h0,16'h0,0,1,16'h2222,8'h06,16'h0};
    tbl[2] = '{1,0,0,0,16'h0,16'h0,0,1,16'h3333,8'h86,16'h0};
    tbl[3] = '{1,0,1,1,16'h2000,16'hFFFF,0,1,16'h4444,8'h8E,16'h2000};
    tbl[4] = '{1,0,0,1,16'h0,16'hABCD,0,0,16'h5555,8'h82,16'h0};
    tbl[5] = '{1,0,1,0,16'h1234,16'h0,0,0,16'h6666,8'h82,16'h0};
    tbl[6] = '{1,0,0,0,16'h0,16'h0,1,0,16'hBEEF,8'hA2,16'h0};
    tbl[7] = '{0,0,0,0,16'h0,16'h0,0,1,16'h7777,8'h86,16'h0};
    tbl[8] = '{0,0,0,0,16'h0,16'h0,0,1,16'h8888,8'h06,16'h0};
    tbl[9] = '{0,0,0,0,16'h0,16'h0,1,1,16'h9999,8'h06,16'h0};

    do_reset();
    chk("reset_out", obs, 8'h06);
    chk("reset_wdata", m_wrt_data, 16'h0);

    // Single A2D transaction with routing checks.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_in(tbl[i].q0, tbl[i].q1, tbl[i].w0, tbl[i].w1,
             tbl[i].d0, tbl[i].d1, tbl[i].md, tbl[i].ss);
      m_rd_data = tbl[i].rd;
      #2;
      chk($sformatf("tbl%0d_out", i), obs, tbl[i].eo);
      chk($sformatf("tbl%0d_wdata", i), m_wrt_data, tbl[i].ed);
      chk($sformatf("tbl%0d_rd", i), rd_data, tbl[i].rd);
    end

    // Tie after reset, gap timing, round robin.
    do_reset();
    cyc(1, 1, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 0, 0, 1);
    chk("tie_first", {gnt0, gnt1}, 2'b10);
    cyc(0, 1, 0, 0, 0, 0, 0, 1);
    chk("tie_hold", {gnt0, gnt1}, 2'b10);
    fk = 0;
    for (int k = 1; k <= 20 && fk == 0; k++) begin
      cyc(0, 1, 0, 0, 0, 0, 0, 1);
      if (k == 1) chk("tie_drop", {gnt0, gnt1}, 2'b00);
      if (gnt1) fk = k;
    end
    chk("tie_gap", fk, GAP + 2);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      cyc(1, 1, 0, 0, 0, 0, 0, 1);
      if (gnt0 || gnt1) begin
        found = 1;
        chk("tie_rr", {gnt0, gnt1}, 2'b10);
      end
    end
    chk("tie_rr_seen", found, 1);

    // A2D burst: cmd, done, dead cycle, read, done.
    do_reset();
    nd0 = 0; nd1 = 0; drop = 0; g1seen = 0;
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 0, 0, 1);
    chk("burst_gnt", {gnt0, gnt1}, 2'b10);
    for (int s = 0; s < 11; s++) begin
      case (s)
        0: cyc(1, 1, 1, 0, 16'h2000, 0, 0, 1);
        1, 2, 3: cyc(1, 1, 0, 0, 0, 0, 0, 0);
        4: cyc(1, 1, 0, 0, 0, 0, 1, 0);
        5: cyc(1, 1, 0, 0, 0, 0, 0, 1);
        6: cyc(1, 1, 1, 0, 16'h0001, 0, 0, 1);
        7, 8: cyc(1, 1, 0, 0, 0, 0, 0, 0);
        9: cyc(1, 1, 0, 0, 0, 0, 1, 0);
        default: cyc(1, 1, 0, 0, 0, 0, 0, 1);
      endcase
      if (s == 0) chk("burst_w1", {m_wrt, m_wrt_data},
                      {1'b1, 16'h2000});
      if (s == 6) chk("burst_w2", {m_wrt, m_wrt_data},
                      {1'b1, 16'h0001});
      if (done0) nd0++;
      if (done1) nd1++;
      if (!gnt0) drop++;
      if (gnt1) g1seen++;
    end
    chk("burst_done0", nd0, 2);
    chk("burst_done1", nd1, 0);
    chk("burst_nodrop", drop, 0);
    chk("burst_g1", g1seen, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 1);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      cyc(0, 1, 0, 0, 0, 0, 0, 1);
      if (gnt1) found = k + 1;
    end
    chk("burst_pend", found, GAP + 2);

    // Idle owner timeout and lockout until re-request.
    do_reset();
    gi = -1; ti = -1; regr = 0;
    for (int n = 0; n < 45; n++) begin
      cyc(1, 0, 0, 0, 0, 0, 0, 1);
      if (gnt0 && gi < 0) gi = n;
      if (tmo && ti < 0) begin
        ti = n;
        chk("tmo_gnt", {gnt0, SS_n0}, 2'b01);
      end
      if (ti >= 0 && gnt0) regr++;
    end
    chk("tmo_time", ti - gi, TMO);
    chk("tmo_lock", regr, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    chk("tmo_regrant", gnt0, 1'b1);

    // Reset while a transfer is in flight.
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 1, 0, 16'h5A5A, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("mid_busy", {gnt0, SS_n0}, 2'b10);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1, 0, 0, 0, 0, 0, 1, 0);
    #2;
    chk("mid_rst", obs, 8'h06);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    chk("mid_regrant", {gnt0, gnt1}, 2'b10);

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    rq = 2'b00;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst_n = ($urandom % 800) != 0;
      for (int i = 0; i < 2; i++) begin
        if ($urandom % 12 == 0) rq[i] = ~rq[i];
        wr[i] = ($urandom % 6) == 0;
        wd[i] = 16'($urandom);
      end
      set_in(rq[0], rq[1], wr[0], wr[1], wd[0], wd[1],
             (xfer == 1) || (xfer == 0 && $urandom % 32 == 0),
             xfer == 0);
      m_rd_data = 16'($urandom);
      #2;
      chk("rnd_out", obs, m_obs(m_done, m_SS_n));
      chk("rnd_wdata", m_wrt_data,
          m_fwd() ? wd[own] : 16'h0);
      model_step(rst_n, m_done);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_share_arb.md
Name: spi_share_arb

Overview:
- Arbitrates one SPI_mnrch master between two requesters: requester 0 (A2D_intf load-cell/steer/battery reads) and requester 1 (inertial sensor interface).
- Grants are burst-locked: a requester holds the master across multi-transaction sequences, e.g. the A2D command + dead cycle + read pair.
- Routes the master's SS_n to the owning slave's chip select and routes done back to the owner only.
- Round-robin fairness, a guard gap between owners, and an idle-owner timeout.

Parameters:
- GAP_CYC, 4, cycles of forced idle after a grant is released before any new grant (minimum 1).
- TMO_CYC, 1024, cycles an owner may hold the grant with no transaction in flight and no wrt before the grant is revoked.
- TMO_W, 11, width of the timeout counter; must hold TMO_CYC.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req0, req1  in  1 each  level request, held for the whole burst
- wrt0, wrt1  in  1 each  start-transaction pulse from the requester
- wrt_data0, wrt_data1  in  16 each  transaction data from the requester
- gnt0, gnt1  out  1 each  registered grant
- done0, done1  out  1 each  routed transaction-complete pulse
- rd_data  out  16  master rd_data, broadcast to both requesters
- m_wrt  out  1  to SPI_mnrch wrt
- m_wrt_data  out  16  to SPI_mnrch wrt_data
- m_done  in  1  from SPI_mnrch done
- m_rd_data  in  16  from SPI_mnrch rd_data
- m_SS_n  in  1  from SPI_mnrch SS_n
- SS_n0, SS_n1  out  1 each  chip select to the A2D and to the inertial sensor
- tmo  out  1  one-cycle pulse when a grant is revoked by timeout

Interface decisions:
- One clock, clk.
- Reset rst_n is synchronous and active-low.

Behaviour:
- Reset values: gnt0 = gnt1 = 0, done0 = done1 = 0, m_wrt = 0, m_wrt_data = 0, SS_n0 = SS_n1 = 1, tmo = 0.
- Reset state: state = IDLE, busy = 0, last_owner = 1 (so requester 0 wins the first tie).
- States:
  - IDLE: no owner.
  - OWN: owner register valid.
  - GAP: counting GAP_CYC cycles.
- IDLE:
  - If req0 or req1 in cycle n, the grant register is set at edge n+1 and state goes to OWN.
  - If both request, grant the requester != last_owner.
- OWN:
  - m_wrt = owner's wrt and m_wrt_data = owner's wrt_data, combinational, same cycle.
  - When no wrt is being forwarded, m_wrt = 0 and m_wrt_data holds 0.
  - busy sets on a forwarded wrt and clears on m_done.
  - A wrt from the non-owner is ignored and never reaches the master.
  - A wrt from the owner while busy is ignored; the master is never re-triggered mid-transfer.
- Routing:
  - done_owner = m_done while busy.
  - done for the non-owner is always 0.
  - rd_data = m_rd_data at all times.
  - SS_n_owner = m_SS_n while in OWN; the other chip select is held at 1.
  - Both chip selects are 1 in IDLE and GAP.
- Release:
  - If the owner's req = 0 and !busy in cycle n, gnt drops at n+1, last_owner is updated to that owner, and state goes to GAP.
  - If req drops while busy, the grant is held until m_done. Release then happens the cycle after m_done; the done pulse is still delivered.
- Dead cycle: A2D drops nothing between its two transactions. req stays high through the one-cycle dead state, so the grant is kept.
- GAP:
  - Counter runs 0 → GAP_CYC-1, then state goes to IDLE.
  - req is sampled only in IDLE, so the earliest re-grant is GAP_CYC+1 cycles after gnt drops.
- Timeout:
  - The counter increments each OWN cycle with !busy and no forwarded wrt.
  - It clears on a forwarded wrt and on entering OWN.
  - On reaching TMO_CYC: tmo pulses, gnt drops, and state goes to GAP.
  - The revoked owner must drop req and re-request.
  - The timeout counter never runs while busy.
- Simultaneous events:
  - m_done and the owner's req drop in the same cycle: treated as not busy, release next edge.
  - Owner's wrt and timeout expiry in the same cycle: the wrt wins and the counter clears.
- Reset mid-transfer: the grant is dropped and state goes to IDLE at that edge. The master is reset by the same rst_n, so no stale done is routed.

Decomposition:
- Shared package spi_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, OWN, GAP} arb_state_t
  - owner index typedef: logic, 0 = A2D, 1 = inertial
- No sub-module is needed; the timeout and gap counters share one TMO_W-wide counter inside the block.

Test Plan:
- req0 only at cycle 5, wrt0 at cycle 7 with wrt_data0=16'h2000, m_done at 40 → gnt0=1 at edge 6; m_wrt and m_wrt_data=16'h2000 at cycle 7; SS_n0 follows m_SS_n and SS_n1=1; done0 pulse at 40; done1=0.
- req0 and req1 both rise in the same IDLE cycle right after reset → gnt0 first. After release and GAP_CYC=4 with req1 still high, gnt1 asserts 5 cycles after gnt0 falls. Next tie goes to requester 0 again.
- A2D burst: wrt0 16'h2000 → done → 1-cycle dead → wrt0 16'h0001 → done, req0 held throughout → gnt0 never drops; two done0 pulses; req1 stays pending until release.
- Non-owner wrt1 pulsed while gnt0=1, and owner wrt0 pulsed while busy → m_wrt stays 0 for both; the in-flight transfer completes normally.
- TMO_CYC=16, owner holds req0 with no wrt → tmo pulse and gnt0=0 exactly 16 idle OWN cycles after the grant; SS_n0=1.
- rst_n=0 mid-transfer (busy=1) → next edge: gnt0=0, SS_n0=SS_n1=1, done0=0; the arbiter re-grants normally after reset.
